counter_sched: RTL
==================

Name: counter_sched

Overview:
- Scheduler that shares one down-counting interval timer among NREQ requesters.
- Each requester asks for a delay of D cycles. The block arbitrates, loads the shared counter, holds the winner's grant while counting, and then pulses that requester's done.
- Sits between client blocks and the shared counter datapath. It is the only owner of the counter value.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 4, counter width; max delay 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester request level; must be held until done.
- delay  input  NREQ*CNT_W  requester i's delay in bits [i*CNT_W +: CNT_W].
- grant  output  NREQ  one-hot owner of the counter; 0 when idle.
- done  output  NREQ  one-cycle completion pulse to the owner.
- busy  output  1  high while in COUNT or DONE.
- cnt  output  CNT_W  current shared counter value.

Behaviour:
- All outputs are registered.
- Reset: at a rising edge with rst=1:
  - state=IDLE, grant=0, done=0, busy=0, cnt=0, rr pointer=0.
  - rst overrides every other condition.
- Reset mid-operation abandons the job with no done pulse.
- IDLE state:
  - At an edge where req!=0, pick the first requester with req high, searching from pointer upward with wrap NREQ-1 -> 0. Call it i.
  - Next values: grant=onehot(i), cnt=delay[i], busy=1, state=COUNT, pointer=(i+1) mod NREQ.
  - If req==0: stay in IDLE, all outputs 0.
- delay[i] is sampled only at the grant edge. Later changes are ignored.
- COUNT state, evaluated at each edge:
  - Abort: if req[i]==0, then grant=0, cnt=0, busy=0, state=IDLE. No done. The pointer keeps its advanced value.
  - Else, if cnt!=0: cnt=cnt-1.
  - Else (cnt==0): grant=0, done[i]=1, state=DONE.
- DONE state: next edge sets done=0, busy=0, state=IDLE. No arbitration happens in DONE.
- Timing for a delay of D:
  - grant is high for exactly D+1 cycles.
  - done rises D+1 edges after the grant edge.
  - The earliest next grant comes 2 edges after done rises, so back-to-back jobs have a period of D+3 cycles.
- D=0: grant is high for 1 cycle, then done.
- cnt never wraps below 0. Maximum D=2^CNT_W-1 gives 2^CNT_W grant cycles.
- Invariants:
  - grant is one-hot or zero.
  - done is one-hot or zero, and never coincides with grant.
  - done bit i is only ever set after grant bit i.
- A requester still holding req after its done is re-eligible in IDLE. Round-robin gives the other pending requesters priority first.

Optional Feature:
- Macro: COUNTER_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The rr pointer is removed and no other behaviour changes.
- Undefined (default): round-robin as above.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 and all delays 5 -> grant=0, done=0, busy=0, cnt=0 throughout. After release, first grant is 4'b0001.
- Single job: req=4'b0010, delay1=3 -> grant=4'b0010 after the first edge; cnt 3,2,1,0; grant held 4 cycles; then done=4'b0010 for 1 cycle; busy drops the following cycle.
- Fairness: req=4'b1111 held, all delays 0 -> grant sequence 0001,0010,0100,1000,0001, each 1 cycle, period 3 cycles, with a done per job. With COUNTER_SCHED_FIXED_PRIO_EN, grant is 0001 every time.
- Max delay: req=4'b1000, delay3=15 -> grant held 16 cycles, cnt steps 15..0, then done=4'b1000.
- Abort: req2 with delay2=9; drop req2 when cnt=5 -> next edge grant=0, cnt=0, busy=0, no done pulse, state IDLE. A pending req0 is granted on the following edge.
- Reset mid-job: req0 with delay0=12; assert rst when cnt=7 -> next edge all outputs 0, no done. After release, pointer=0.

Source files
------------

// File: rtl/counter_sched.sv
// Shared down-counting interval timer with round-robin arbitration among NREQ requesters.
// Define COUNTER_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module counter_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CNT_W-1:0]   delay,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [CNT_W-1:0]        cnt
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    own;
  logic [PTR_W-1:0]    win_c;
  logic [CNT_W-1:0]    load_c;
  logic                own_req_c;
  logic [NREQ*CNT_W-1:0] delay_sh_c;
  logic [NREQ-1:0]     req_sh_c;

`ifndef COUNTER_SCHED_FIXED_PRIO_EN
  logic [PTR_W-1:0]    ptr;
`endif

  // First requester with req high, searching upward from base with wrap.
  function automatic logic [PTR_W-1:0] pick(input logic [NREQ-1:0] r,
                                            input logic [PTR_W-1:0] base);
    logic [PTR_W-1:0] w;
    logic [NREQ-1:0]  rs;
    int unsigned      k;
    w = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      k  = (32'(base) + 32'(j)) % NREQ;
      rs = r >> k;
      if (rs[0]) w = PTR_W'(k);
    end
    return w;
  endfunction

  always_comb begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
    win_c = pick(req, PTR_W'(0));
`else
    win_c = pick(req, ptr);
`endif
    delay_sh_c = delay >> (32'(win_c) * CNT_W);
    load_c     = delay_sh_c[CNT_W-1:0];
    req_sh_c   = req >> own;
    own_req_c  = req_sh_c[0];
  end

  // Single-process FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      own   <= '0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            grant <= NREQ'(1) << win_c;
            cnt   <= load_c;
            busy  <= 1'b1;
            own   <= win_c;
            state <= COUNT;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
            ptr   <= (32'(win_c) == NREQ - 1) ? '0 : win_c + PTR_W'(1);
`endif
          end else begin
            grant <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        COUNT: begin
          if (!own_req_c) begin
            // Owner withdrew: abandon the job silently.
            grant <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            done  <= grant;
            grant <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          done  <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
